// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_if                                                 |
// | Brief    : Scan-coordinate / colour-return / DAC bundle of the VGA       |
// |            timing controller.                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface vga_timing_if;
    logic        [7:0]  RGBin;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               startOfFrame;
    logic               endOfFrame;
    logic               hsync;
    logic               vsync;
    logic               blankN;
    logic        [7:0]  red;
    logic        [7:0]  green;
    logic        [7:0]  blue;

    // master = the timing controller, slave = drawers/mux/DAC side
    modport master (
        input  RGBin,
        output pixelX, pixelY, startOfFrame, endOfFrame,
        output hsync, vsync, blankN, red, green, blue
    );

    modport slave (
        output RGBin,
        input  pixelX, pixelY, startOfFrame, endOfFrame,
        input  hsync, vsync, blankN, red, green, blue
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_controller                                         |
// | Brief    : VGA scan counters, pipeline-aligned sync/blank and 3-3-2 to   |
// |            8-8-8 colour expansion, plus frame pulses.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vga_timing_controller #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic         clk,
    input  logic         resetN,
    vga_timing_if.master vga
);

    localparam logic [10:0] c_h_total = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] c_v_total = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] c_h_last  = c_h_total - 11'd1;
    localparam logic [10:0] c_v_last  = c_v_total - 11'd1;
    localparam logic [10:0] c_h_vis   = 11'(H_VISIBLE);
    localparam logic [10:0] c_v_vis   = 11'(V_VISIBLE);
    localparam logic [10:0] c_hs_beg  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_vs_beg  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_end  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t c_idle = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        r_sof;
    logic        r_eof;
    logic        w_h_last;
    logic        w_v_last;
    sync_t       w_raw;
    sync_t       w_dly_out;
    sync_t       r_dly [PIPE_DELAY];
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic [2:0]  w_r;
    logic [2:0]  w_g;
    logic [1:0]  w_b;

    assign w_h_last = (r_h == c_h_last);
    assign w_v_last = (r_v == c_v_last);

    assign w_raw.hs  = !((r_h >= c_hs_beg) && (r_h < c_hs_end));
    assign w_raw.vs  = !((r_v >= c_vs_beg) && (r_v < c_vs_end));
    assign w_raw.vis = (r_h < c_h_vis) && (r_v < c_v_vis);

    // Frame flags are decoded one clock early so they line up with the counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_h   <= '0;
            r_v   <= '0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
        end else begin
            r_sof <= w_h_last && w_v_last;
            r_eof <= w_h_last && (r_v == c_v_vis - 11'd1);
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_dly[i] <= c_idle;
            end
        end else begin
            r_dly[0] <= w_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_dly_out = r_dly[PIPE_DELAY-1];
    assign w_r       = vga.RGBin[7:5];
    assign w_g       = vga.RGBin[4:2];
    assign w_b       = vga.RGBin[1:0];

    // Bit replication maps full-scale 3/2-bit codes onto exactly 8'hFF
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else begin
            r_hsync   <= w_dly_out.hs;
            r_vsync   <= w_dly_out.vs;
            r_blank_n <= w_dly_out.vis;
            if (w_dly_out.vis) begin
                r_red   <= {w_r, w_r, w_r[2:1]};
                r_green <= {w_g, w_g, w_g[2:1]};
                r_blue  <= {w_b, w_b, w_b, w_b};
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign vga.pixelX       = $signed(r_h);
    assign vga.pixelY       = $signed(r_v);
    assign vga.startOfFrame = r_sof;
    assign vga.endOfFrame   = r_eof;
    assign vga.hsync        = r_hsync;
    assign vga.vsync        = r_vsync;
    assign vga.blankN       = r_blank_n;
    assign vga.red          = r_red;
    assign vga.green        = r_green;
    assign vga.blue         = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_timing_controller                                      |
// | Brief    : Scoreboard bench on a shrunken 16x11 raster, PIPE_DELAY=2.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_timing_controller;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int PD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LAT = PD + 1;
    localparam int FRAME = HT * VT;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if vif();

    vga_timing_controller #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .PIPE_DELAY(PD)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .vga   (vif)
    );

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   active = 1'b0;
    int   mon_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Pixel index p counts clocks since reset release; negative = before release
    function automatic logic [7:0] colour_of(input int p);
        int h, v;
        if (p < 0) return 8'hFF;
        h = p % HT;
        v = (p / HT) % VT;
        if (h == 0 && v == 0) return 8'h1C;
        if (h == 1 && v == 0) return 8'hE0;
        if (h == 2 && v == 0) return 8'h03;
        if (h == 3 && v == 0) return 8'hFF;
        if (h >= HV || v >= VV) return 8'hFF;
        return 8'(h * 37 + v * 11 + 5);
    endfunction

    function automatic exp_t expect_for(input int p);
        exp_t e;
        int h, v;
        logic [7:0] c, r8, g8, b8;
        h = p % HT;
        v = (p / HT) % VT;
        e.hs = !(h >= HV + HF && h < HV + HF + HS);
        e.vs = !(v >= VV + VF && v < VV + VF + VS);
        e.bn = (h < HV) && (v < VV);
        c  = colour_of(p);
        r8 = {5'b0, c[7:5]};
        g8 = {5'b0, c[4:2]};
        b8 = {6'b0, c[1:0]};
        if (!e.bn) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end else if (h == 0 && v == 0) begin
            e.r = 8'h00; e.g = 8'hFF; e.b = 8'h00;
        end else if (h == 1 && v == 0) begin
            e.r = 8'hFF; e.g = 8'h00; e.b = 8'h00;
        end else if (h == 2 && v == 0) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'hFF;
        end else if (h == 3 && v == 0) begin
            e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
        end else begin
            e.r = (r8 << 5) | (r8 << 2) | (r8 >> 1);
            e.g = (g8 << 5) | (g8 << 2) | (g8 >> 1);
            e.b = (b8 << 6) | (b8 << 4) | (b8 << 2) | b8;
        end
        return e;
    endfunction

    // Monitor: counters and frame pulses from its own cycle count, DAC side from the scoreboard
    always @(negedge clk) begin
        int   n, px, py;
        exp_t e;
        if (active) begin
            n  = mon_n;
            px = n % HT;
            py = (n / HT) % VT;
            check("pixelX", 32'(vif.pixelX), 32'(px));
            check("pixelY", 32'(vif.pixelY), 32'(py));
            check("startOfFrame", 32'(vif.startOfFrame), 32'(n > 0 && px == 0 && py == 0));
            check("endOfFrame", 32'(vif.endOfFrame), 32'(px == 0 && py == VV));
            if (n < LAT) begin
                e = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};
            end else if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
                e = '{hs: 1'bx, vs: 1'bx, bn: 1'bx, r: 8'hxx, g: 8'hxx, b: 8'hxx};
            end else begin
                e = sb_q.pop_front();
            end
            check("hsync",  32'(vif.hsync),  32'(e.hs));
            check("vsync",  32'(vif.vsync),  32'(e.vs));
            check("blankN", 32'(vif.blankN), 32'(e.bn));
            check("red",    32'(vif.red),    32'(e.r));
            check("green",  32'(vif.green),  32'(e.g));
            check("blue",   32'(vif.blue),   32'(e.b));
            mon_n++;
        end
    end

    task automatic check_reset_outputs();
        check("rst_pixelX",       32'(vif.pixelX),       32'd0);
        check("rst_pixelY",       32'(vif.pixelY),       32'd0);
        check("rst_startOfFrame", 32'(vif.startOfFrame), 32'd0);
        check("rst_endOfFrame",   32'(vif.endOfFrame),   32'd0);
        check("rst_hsync",        32'(vif.hsync),        32'd1);
        check("rst_vsync",        32'(vif.vsync),        32'd1);
        check("rst_blankN",       32'(vif.blankN),       32'd0);
        check("rst_red",          32'(vif.red),          32'd0);
        check("rst_green",        32'(vif.green),        32'd0);
        check("rst_blue",         32'(vif.blue),         32'd0);
    endtask

    // Called in the settle window just after a rising edge: state 0 starts here
    task automatic release_and_run(input int cycles);
        sb_q.delete();
        mon_n  = 0;
        active = 1'b1;
        resetN = 1'b1;
        for (int n = 0; n < cycles; n++) begin
            vif.RGBin = colour_of(n - PD);
            sb_q.push_back(expect_for(n));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vif.RGBin = 8'hFF;
        resetN    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();

        // Stop at pixel (14,3) of frame 2, where the DAC side shows pixel 11 (hsync low)
        release_and_run(FRAME + 3 * HT + 14);
        check("pre_reset_hsync", 32'(vif.hsync), 32'd0);
        active = 1'b0;
        #1 resetN = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;

        release_and_run(2 * FRAME + 10);
        active = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
